switch_egress_buffer: RTL

Per-output-port egress stage placed directly downstream of `very_simple_switch`; one instance consumes one `data_out_valid[i]` / `data_out[i]` pair. The switch output has no backpressure, so this block absorbs words into a FIFO and presents them to the outbound link with a valid/ready handshake. Words arriving while the buffer is full are dropped and counted. Occupancy statistics are exported for monitoring.

---
 rtl/switch_pkg.sv | 9 +
 rtl/sync_fifo_core.sv | 69 ++++++
 rtl/switch_egress_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: default word width, word type and output port count.
package switch_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned OUTPUT_QTY = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : switch_pkg

// File: rtl/sync_fifo_core.sv
// Synchronous circular-buffer FIFO: storage, wrapping pointers and an
// explicit occupancy register.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push_i / wdata_i    write a word at the write pointer
//   pop_i               retire the head word
//   rdata_o             word at the read pointer (raw, not zeroed)
//   occ_o               current stored word count
//   occ_next_o          word count after the coming edge
//   full_o / empty_o    occupancy at DEPTH / at zero
// The caller must not push while full unless it also pops.
module sync_fifo_core #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned OCC_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [OCC_WIDTH-1:0]  occ_o,
  output logic [OCC_WIDTH-1:0]  occ_next_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop_i);
    occ_d    = occ_q + OCC_WIDTH'(push_i) - OCC_WIDTH'(pop_i);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign occ_o      = occ_q;
  assign occ_next_o = occ_d;
  assign full_o     = (occ_q == OCC_WIDTH'(DEPTH));
  assign empty_o    = (occ_q == '0);

endmodule : sync_fifo_core

// File: rtl/switch_egress_buffer.sv
// Per-port egress buffer behind the switch: absorbs words with no
// backpressure, presents them first-word-fall-through over valid/ready,
// drops and counts words arriving while full, and tracks occupancy stats.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   in_valid, in_data        word from the switch output
//   out_valid, out_ready     downstream handshake
//   out_data                 head word, zero when nothing is stored
//   occupancy, almost_full   current fill level and threshold flag
//   drop_count, high_water   saturating drop count, peak occupancy
//   clear_stats              synchronous clear of drop_count / high_water
module switch_egress_buffer #(
  parameter int unsigned DATA_WIDTH  = switch_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned OCC_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic                  almost_full,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [OCC_WIDTH-1:0]  high_water,
  input  logic                  clear_stats
);

  logic                  push, pop, drop;
  logic                  full, empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic [OCC_WIDTH-1:0]  occ_next;

  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [OCC_WIDTH-1:0]  high_water_q, high_water_d;
  logic                  almost_full_q, almost_full_d;

  // When full, a same-cycle pop frees the slot the push will use.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  sync_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .OCC_WIDTH  (OCC_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (in_data),
    .rdata_o    (head_data),
    .occ_o      (occupancy),
    .occ_next_o (occ_next),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Statistics next-state; clear wins over a coincident drop or peak update.
  always_comb begin
    drop_count_d  = drop_count_q;
    high_water_d  = high_water_q;
    almost_full_d = (occ_next >= OCC_WIDTH'(AFULL_LEVEL));
    if (clear_stats) begin
      drop_count_d = '0;
      high_water_d = occ_next;
    end else begin
      if (drop && (drop_count_q != '1)) begin
        drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end
      if (occ_next > high_water_q) begin
        high_water_d = occ_next;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q  <= '0;
      high_water_q  <= '0;
      almost_full_q <= 1'b0;
    end else begin
      drop_count_q  <= drop_count_d;
      high_water_q  <= high_water_d;
      almost_full_q <= almost_full_d;
    end
  end

  // out_valid derives only from the occupancy register, never from out_ready.
  assign out_valid   = !empty;
  assign out_data    = out_valid ? head_data : '0;
  assign almost_full = almost_full_q;
  assign drop_count  = drop_count_q;
  assign high_water  = high_water_q;

endmodule : switch_egress_buffer
